serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes `a - b` one bit per clock, LSB first. It builds a full-subtract cell each cycle from two `half_subtractor` instances plus a registered borrow. It sits directly around the existing half-subtractor cell, consuming its difference/borrow outputs. It presents a start/busy/done handshake to the controlling logic.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥2).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled only when not busy.
- `a`  input  WIDTH  minuend; captured when start is accepted.
- `b`  input  WIDTH  subtrahend; captured when start is accepted.
- `busy`  output  1  high while a subtraction is in progress.
- `done`  output  1  one-cycle pulse when `diff`/`borrow_out` become valid.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow_out`  output  1  final borrow; 1 iff `a < b` unsigned.
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States:
  - IDLE: `busy=0`.
  - RUN: `busy=1`.
- Transitions:
  - IDLE→RUN on a clock edge with `start=1`.
  - RUN→IDLE after WIDTH bit steps.
- On accept:
  - Load operand shift registers with `a` and `b`.
  - Clear the borrow register and the bit counter.
  - Clear `diff` and `borrow_out` to 0.
- Per RUN cycle, for bit i:
  - HS1: `(a_i, b_i)` → `d1 = a_i ^ b_i`, `bo1 = ~a_i & b_i`.
  - HS2: `(d1, bin)` → `d = d1 ^ bin`, `bo2 = ~d1 & bin`.
  - Next borrow `bin' = bo1 | bo2`.
  - `d` shifts into the MSB of the result register; the register shifts right.
- Counter: width `$clog2(WIDTH)`; increments 0..WIDTH-1 and does not wrap.
- Completion: at terminal count, `borrow_out` takes the final `bin'`.
- Hold: `diff` and `borrow_out` hold their values until the next accepted `start`.
- `start` while busy is ignored; operands are not re-sampled.
- `a` and `b` may change freely after acceptance.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE;
  - `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `ovf=0`;
  - counter, borrow and shift registers to 0.
- Reset mid-operation aborts the operation; no `done` is produced.
- Sequence for `start` sampled at edge k:
  - `busy=1` from edge k.
  - Bits are processed at edges k+1 … k+WIDTH.
  - At edge k+WIDTH: `busy=0`, `done=1`, results valid.
  - At edge k+WIDTH+1: `done=0`.
- Latency is WIDTH cycles from accept to `done`.
- Back-to-back: `start=1` in the `done` cycle is accepted at edge k+WIDTH+1. This gives throughput of one result per WIDTH+1 cycles.
- `done` and `busy` are never both high.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the captured operand MSBs.
  - `ovf` is registered with `diff`, is valid on `done`, and is cleared on accept and on reset.
- Undefined: port `ovf` and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg`:
  - state encodings `ST_IDLE=1'b0`, `ST_RUN=1'b1`;
  - default width constant `SERIAL_SUB_WIDTH=8`.
- Sub-module: the existing `half_subtractor`, instantiated twice (HS1, HS2) to form the per-bit full-subtract cell. No other hierarchy.

## Test plan
All scenarios use WIDTH=8.
- `a=0x05`, `b=0x03`, `start` pulse → `done` 8 cycles later, `diff=0x02`, `borrow_out=0`.
- `a=0x03`, `b=0x05` → `diff=0xFE`, `borrow_out=1`. `a=0x00`, `b=0x00` → `diff=0x00`, `borrow_out=0`.
- With `SERIAL_SUB_OVF_EN`: `a=0x80`, `b=0x01` → `diff=0x7F`, `borrow_out=0`, `ovf=1`. `a=0x7F`, `b=0x01` → `diff=0x7E`, `ovf=0`.
- `start` held high with `a=0x10`, `b=0x01`, operands changed to `0xFF`/`0xFF` at cycle 3 → exactly one `done` per 9 cycles. First result `diff=0x0F`; the second operation starts in the `done` cycle using `0xFF`/`0xFF` → `0x00`.
- `rst_n` asserted at RUN cycle 4 → `busy`/`diff`/`borrow_out` go to 0 immediately, no `done`. A new `start` after release yields a correct result.
- Exhaustive 4-bit sweep (WIDTH=4, all 256 pairs) compared against a reference `a-b` model, including `borrow_out`.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and default width.
package serial_sub_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam int SERIAL_SUB_WIDTH = 8;
endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor cell: diff = a ^ b, borrow when a=0 and b=1.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b;
  assign borrow = ~a & b;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  // Handshake: start is sampled on a rising edge only while busy is low; the
  // operands are captured on that edge. done pulses for one cycle exactly
  // when diff/borrow_out become valid, and busy/done are never high together.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bin;
  logic             d1;
  logic             bo1;
  logic             d;
  logic             bo2;
  logic             bin_next;
  logic             last;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  half_subtractor hs1 (.a(a_sr[0]), .b(b_sr[0]), .diff(d1), .borrow(bo1));
  half_subtractor hs2 (.a(d1),      .b(bin),     .diff(d),  .borrow(bo2));

  assign bin_next = bo1 | bo2;
  assign last     = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      bin        <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          state      <= ST_RUN;
          a_sr       <= a;
          b_sr       <= b;
          bin        <= 1'b0;
          cnt        <= '0;
          diff       <= '0;
          borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf        <= 1'b0;
          a_msb      <= a[WIDTH-1];
          b_msb      <= b[WIDTH-1];
`endif
        end
      end else begin
        // Result enters at the MSB so after WIDTH shifts bit 0 lands at diff[0].
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        bin  <= bin_next;
        diff <= {d, diff[WIDTH-1:1]};
        if (last) begin
          state      <= ST_IDLE;
          done       <= 1'b1;
          borrow_out <= bin_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit directed vector table, held-start and
// mid-run reset sequences, and an exhaustive 4-bit sweep on a second instance.
module tb_serial_subtractor;
  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8;
  logic       ovf4;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [4:0] exp4_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;
  vec_t vecs[10];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish before 2 ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Driver: one 8-bit operation; a start pulse while busy must be ignored.
  task automatic run8(input vec_t v, input string name);
    int cyc;
    logic [7:0] exp_d;
    @(negedge clk);
    a8 = v.a; b8 = v.b; start8 = 1'b1;
    exp_q.push_back(v.diff);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~v.a; b8 = ~v.b;
    check({name, " busy_on_accept"}, 32'(busy8), 32'd1);
    check({name, " cleared_on_accept"}, {23'd0, borrow8, diff8}, 32'd0);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      if (cyc == 3) start8 = 1'b1;
      if (cyc == 4) start8 = 1'b0;
      @(posedge clk); #1;
      cyc++;
      check({name, " busy_done_excl"}, 32'(busy8 & done8), 32'd0);
    end
    start8 = 1'b0;
    check({name, " latency"}, 32'(cyc), 32'd8);
    exp_d = exp_q.pop_front();
    if (done8) begin
      check({name, " diff"}, 32'(diff8), 32'(exp_d));
      check({name, " borrow"}, 32'(borrow8), 32'(v.borrow));
      check({name, " busy_at_done"}, 32'(busy8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check({name, " ovf"}, 32'(ovf8), 32'(v.ovf));
`endif
    end
    @(posedge clk); #1;
    check({name, " done_pulse_end"}, 32'(done8), 32'd0);
    check({name, " diff_hold"}, {23'd0, borrow8, diff8}, {23'd0, v.borrow, v.diff});
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv);
    int cyc;
    logic [4:0] exp_r;
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    exp4_q.push_back({1'b0, av} - {1'b0, bv});
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp_r = exp4_q.pop_front();
    check($sformatf("sweep4 %0h-%0h", av, bv), {21'd0, cyc[5:0], borrow4, diff4},
          {21'd0, 6'd4, exp_r[4], exp_r[3:0]});
`ifdef SERIAL_SUB_OVF_EN
    check($sformatf("sweep4_ovf %0h-%0h", av, bv), 32'(ovf4),
          32'((av[3] != bv[3]) && (exp_r[3] != av[3])));
`endif
  endtask

  initial begin
    int n_done;
    int cyc;
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("reset_outputs8", {21'd0, busy8, done8, borrow8, diff8}, 32'd0);
    check("reset_outputs4", {25'd0, busy4, done4, borrow4, diff4}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(ovf8), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run8(vecs[i], $sformatf("vec%0d", i));

    // start held high: one result per 9 cycles, second op uses FF/FF.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    n_done = 0;
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin a8 = 8'hFF; b8 = 8'hFF; end
      if (done8) begin
        n_done++;
        if (n_done == 1) begin
          check("held first_done_edge", 32'(e), 32'd8);
          check("held first_result", {23'd0, borrow8, diff8}, 32'h00F);
        end else begin
          check("held second_done_edge", 32'(e), 32'd17);
          check("held second_result", {23'd0, borrow8, diff8}, 32'h000);
        end
      end
      if (e == 9) check("held restart_in_done_cycle", {23'd0, busy8, diff8}, 32'h100);
    end
    check("held done_count", 32'(n_done), 32'd2);
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("held drain", 32'(done8), 32'd1);

    // Reset during RUN cycle 4.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst partial_diff", 32'(diff8), 32'h20);
    rst_n = 1'b0;
    #1;
    check("rst mid_run_clear", {22'd0, busy8, done8, diff8}, 32'd0);
    check("rst borrow_clear", 32'(borrow8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) n_done++; end
    check("rst no_done", 32'(n_done), 32'd0);
    run8(vecs[1], "after_reset");

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run4(4'(x), 4'(y));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
